// File: rtl/sorted_collector_pkg.sv
// ============================================================================
//  sorted_collector_pkg
//  Shared state encodings and widths for the sorter / collector pair.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sorted_collector_pkg;

    localparam int DATA_NUM_DEF = 256;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/collector_mem.sv
// ============================================================================
//  collector_mem
//  Frame buffer: one synchronous write port, one registered read port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module collector_mem
    import sorted_collector_pkg::*;
#(
    parameter int DEPTH  = DATA_NUM_DEF,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] rdata_q;

    // Storage array carries no reset; only the read register does.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sorted_collector.sv
// ============================================================================
//  sorted_collector
//  Captures one sorted frame, checks ordering, sums it, replays via ready/valid.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sorted_collector
    import sorted_collector_pkg::*;
#(
    parameter int DATA_NUM = DATA_NUM_DEF,
    parameter int ADDR_W   = 8,
    parameter int SUM_W    = 16
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              done,
    output logic              order_err,
    output logic              overrun,
    output logic [SUM_W-1:0]  sum_out
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DATA_NUM - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BYTE_W-1:0]  last_q, last_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               order_err_q, order_err_d;
    logic               overrun_q, overrun_d;

    logic               mem_we;
    logic               mem_re;
    logic [ADDR_W-1:0]  mem_raddr;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_d      = last_q;
        sum_d       = sum_q;
        valid_d     = valid_q;
        done_d      = done_q;
        order_err_d = order_err_q;
        overrun_d   = overrun_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_raddr   = rd_ptr_q;

        if (start) begin
            // Flush wins over everything, including a coincident valid_in.
            state_d     = COLLECT;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            last_d      = '0;
            sum_d       = '0;
            valid_d     = 1'b0;
            done_d      = 1'b0;
            order_err_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (valid_in && (state_q != COLLECT)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (valid_in) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        sum_d    = sum_q + {{(SUM_W-BYTE_W){1'b0}}, data_in};
                        last_d   = data_in;
                        if ((wr_ptr_q != '0) && (data_in < last_q)) begin
                            order_err_d = 1'b1;
                        end
                        if (wr_ptr_q == LAST_PTR) begin
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    mem_re    = 1'b1;
                    mem_raddr = '0;
                    rd_ptr_d  = '0;
                    valid_d   = 1'b1;
                    state_d   = DRAIN;
                end
                DRAIN: begin
                    if (valid_q && ready_in) begin
                        if (rd_ptr_q == LAST_PTR) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            rd_ptr_d  = rd_ptr_q + PTR_ONE;
                            mem_re    = 1'b1;
                            mem_raddr = rd_ptr_q + PTR_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= COLLECT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_q      <= '0;
            sum_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            order_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_q      <= last_d;
            sum_q       <= sum_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            order_err_q <= order_err_d;
            overrun_q   <= overrun_d;
        end
    end

    collector_mem #(
        .DEPTH  (DATA_NUM),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .xrst    (xrst),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (data_out)
    );

    assign valid_out = valid_q;
    assign done      = done_q;
    assign order_err = order_err_q;
    assign overrun   = overrun_q;
    assign sum_out   = sum_q;

endmodule

`default_nettype wire
